// File: rtl/regfile_pair.sv
// regfile_pair: a register file with two combinational read ports, one write
// port, and a pair unit. The pair unit treats registers 2p (high half) and
// 2p+1 (low half) as a single double-width value. It can increment, decrement
// or load that value in one edge.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to
// the read ports and to pair_out.
module regfile_pair #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  localparam int AB       = $clog2(NUM_REGS),
  // A two-register file has a single pair; keep the select port one bit wide
  // so that it never collapses to zero width.
  localparam int PB       = (AB > 1) ? AB - 1 : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AB-1:0]         ra_addr,
  output logic [DATA_W-1:0]     ra_data,
  input  logic [AB-1:0]         rb_addr,
  output logic [DATA_W-1:0]     rb_data,
  input  logic                  we,
  input  logic [AB-1:0]         wa_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [PB-1:0]         pair_sel,
  input  logic [1:0]            pair_op,
  input  logic [2*DATA_W-1:0]   pair_in,
  output logic [2*DATA_W-1:0]   pair_out,
  output logic                  pair_wrap,
  output logic                  wr_collide
);

  localparam int PW = 2 * DATA_W;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [AB-1:0] sel_ext;
  logic [AB-1:0] hi_idx;
  logic [AB-1:0] lo_idx;
  logic [PW-1:0] pair_val;
  logic [PW-1:0] pair_next;
  logic          pair_active;
  logic          wrap_hit;
  logic          collide;
  logic          write_ok;

  // Locate the selected pair, compute its next value, and decide whether the
  // single-register write survives this edge.
  always_comb begin
    sel_ext     = AB'(pair_sel);
    hi_idx      = sel_ext << 1;
    lo_idx      = hi_idx | AB'(1);
    pair_val    = {regs[hi_idx], regs[lo_idx]};
    pair_active = (pair_op != OP_NONE);
    pair_next   = pair_val;
    wrap_hit    = 1'b0;
    case (pair_op)
      OP_INC: begin
        pair_next = pair_val + PW'(1);
        wrap_hit  = &pair_val;
      end
      OP_DEC: begin
        pair_next = pair_val - PW'(1);
        wrap_hit  = (pair_val == '0);
      end
      OP_LOAD: pair_next = pair_in;
      default: pair_next = pair_val;
    endcase
    collide  = we && pair_active && ((wa_addr >> 1) == sel_ext);
    write_ok = we && !collide;
  end

  // Register state: reset wins; otherwise the surviving write and the pair
  // update commit together (they never target the same register).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pair_wrap  <= 1'b0;
      wr_collide <= 1'b0;
    end else begin
      if (write_ok) begin
        regs[wa_addr] <= w_data;
      end
      if (pair_active) begin
        regs[hi_idx] <= pair_next[PW-1:DATA_W];
        regs[lo_idx] <= pair_next[DATA_W-1:0];
      end
      if (pair_op == OP_INC || pair_op == OP_DEC) begin
        pair_wrap <= wrap_hit;
      end
      wr_collide <= collide;
    end
  end

  // Combinational read ports and pair view, optionally forwarding the
  // in-flight write.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    ra_data  = (write_ok && ra_addr == wa_addr) ? w_data : regs[ra_addr];
    rb_data  = (write_ok && rb_addr == wa_addr) ? w_data : regs[rb_addr];
    pair_out = {(write_ok && hi_idx == wa_addr) ? w_data : regs[hi_idx],
                (write_ok && lo_idx == wa_addr) ? w_data : regs[lo_idx]};
`else
    ra_data  = regs[ra_addr];
    rb_data  = regs[rb_addr];
    pair_out = pair_val;
`endif
  end

endmodule
